// File: rtl/serial_bit_tx.sv
// Parallel-in, serial-out bit transmitter: accepts a WIDTH-bit word on a ready/valid port and
// sends it MSB first, one bit per clock. Optional even-parity bit enabled by SERIAL_TX_PARITY_EN.
module serial_bit_tx #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned GAP   = 1
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned GW = 4;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_GAP} state_t;
    logic par;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
`endif

    state_t          state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]   cnt;
    logic [GW-1:0]   gap_cnt;

    // The shift register MSB is the line: it holds data, then parity, and is all-zero otherwise.
    assign sdo = shreg[WIDTH-1];

    always_ff @(posedge Clk) begin
        if (rst) begin
            state      <= S_IDLE;
            shreg      <= '0;
            cnt        <= '0;
            gap_cnt    <= '0;
            sdo_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load_valid && load_ready) begin
                        state      <= S_SHIFT;
                        shreg      <= load_data;
                        cnt        <= CNT_LAST;
                        sdo_valid  <= 1'b1;
                        busy       <= 1'b1;
                        load_ready <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
                        par        <= ^load_data;
`endif
                    end else begin
                        load_ready <= 1'b1;
                    end
                end

                S_SHIFT: begin
                    shreg <= {shreg[WIDTH-2:0], 1'b0};
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
`ifndef SERIAL_TX_PARITY_EN
                        done <= (cnt == CW'(1));
`endif
                    end else begin
`ifdef SERIAL_TX_PARITY_EN
                        state <= S_PARITY;
                        shreg <= {par, {(WIDTH-1){1'b0}}};
                        done  <= 1'b1;
`else
                        sdo_valid <= 1'b0;
                        if (GAP != 0) begin
                            state   <= S_GAP;
                            gap_cnt <= GAP_LAST;
                        end else begin
                            state      <= S_IDLE;
                            busy       <= 1'b0;
                            load_ready <= 1'b1;
                        end
`endif
                    end
                end

`ifdef SERIAL_TX_PARITY_EN
                S_PARITY: begin
                    shreg     <= '0;
                    sdo_valid <= 1'b0;
                    if (GAP != 0) begin
                        state   <= S_GAP;
                        gap_cnt <= GAP_LAST;
                    end else begin
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                        load_ready <= 1'b1;
                    end
                end
`endif

                S_GAP: begin
                    if (gap_cnt == '0) begin
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                        load_ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    shreg      <= '0;
                    sdo_valid  <= 1'b0;
                    busy       <= 1'b0;
                    load_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bit_tx.sv
// Scoreboard bench for serial_bit_tx: two instances (GAP=1 and GAP=0) with expected bit
// streams queued at stimulus time and checked by per-instance monitors on the falling edge.
module tb_serial_bit_tx;

`ifdef SERIAL_TX_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       lv_a, ready_a, sdo_a, sv_a, busy_a, done_a;
    logic       lv_b, ready_b, sdo_b, sv_b, busy_b, done_b;
    logic [7:0] data_a, data_b;

    always #5 clk = ~clk;

    serial_bit_tx #(.WIDTH(8), .GAP(1)) dut_a (
        .Clk(clk), .rst(rst), .load_valid(lv_a), .load_ready(ready_a), .load_data(data_a),
        .sdo(sdo_a), .sdo_valid(sv_a), .busy(busy_a), .done(done_a)
    );

    serial_bit_tx #(.WIDTH(8), .GAP(0)) dut_b (
        .Clk(clk), .rst(rst), .load_valid(lv_b), .load_ready(ready_b), .load_data(data_b),
        .sdo(sdo_b), .sdo_valid(sv_b), .busy(busy_b), .done(done_b)
    );

    typedef struct packed {
        logic b;
        logic d;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   done_cyc_b[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic void push_word(input bit which, input logic [7:0] w);
        exp_t e;
        for (int i = 7; i >= 0; i--) begin
            e.b = w[i];
            e.d = (i == 0) && (NB == 8);
            if (which) qb.push_back(e); else qa.push_back(e);
        end
`ifdef SERIAL_TX_PARITY_EN
        e.b = ^w;
        e.d = 1'b1;
        if (which) qb.push_back(e); else qa.push_back(e);
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input bit which, input string name);
        int n = 0;
        while (!(which ? (ready_b && !busy_b) : (ready_a && !busy_a)) && n < 60) begin
            tick;
            n++;
        end
        chk(name, 32'(n < 60), 32'd1);
    endtask

    // Monitor A
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (mon_en) begin
            if (sv_a) begin
                if (qa.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mon_a_extra: got bit %b expected no valid bit", sdo_a);
                end else begin
                    e = qa.pop_front();
                    chk("mon_a_bit", 32'(sdo_a), 32'(e.b));
                    chk("mon_a_done", 32'(done_a), 32'(e.d));
                end
            end else begin
                chk("mon_a_idle_done", 32'(done_a), 32'd0);
                chk("mon_a_idle_sdo", 32'(sdo_a), 32'd0);
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (mon_en) begin
            if (done_b) done_cyc_b.push_back(cyc);
            if (sv_b) begin
                if (qb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mon_b_extra: got bit %b expected no valid bit", sdo_b);
                end else begin
                    e = qb.pop_front();
                    chk("mon_b_bit", 32'(sdo_b), 32'(e.b));
                    chk("mon_b_done", 32'(done_b), 32'(e.d));
                end
            end else begin
                chk("mon_b_idle_done", 32'(done_b), 32'd0);
            end
        end
    end

    initial begin
        int  n;
        bit  acc;
        logic [7:0] c3;
        exp_t e;

        rst = 1'b1; lv_a = 1'b0; lv_b = 1'b0; data_a = '0; data_b = '0;
        c3 = 8'hC3;

        // Reset held for two cycles
        tick;
        mon_en = 1'b1;
        chk("rst_ready", 32'(ready_a), 32'd0);
        chk("rst_valid", 32'(sv_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        tick;
        chk("rst_ready2", 32'(ready_a), 32'd0);
        rst = 1'b0;
        tick;
        repeat (4) begin
            chk("idle_ready_a", 32'(ready_a), 32'd1);
            chk("idle_ready_b", 32'(ready_b), 32'd1);
            chk("idle_valid", 32'(sv_a), 32'd0);
            chk("idle_busy", 32'(busy_a), 32'd0);
            chk("idle_done", 32'(done_a), 32'd0);
            tick;
        end

        // Single word 0xA5 with one gap cycle
        push_word(1'b0, 8'hA5);
        data_a = 8'hA5; lv_a = 1'b1;
        tick;
        lv_a = 1'b0;
        chk("a5_first_valid", 32'(sv_a), 32'd1);
        chk("a5_first_msb", 32'(sdo_a), 32'd1);
        chk("a5_busy", 32'(busy_a), 32'd1);
        chk("a5_ready_low", 32'(ready_a), 32'd0);
        repeat (NB - 1) tick;
        chk("a5_done_last", 32'(done_a), 32'd1);
        tick;
        chk("a5_gap_valid", 32'(sv_a), 32'd0);
        chk("a5_gap_busy", 32'(busy_a), 32'd1);
        chk("a5_gap_ready", 32'(ready_a), 32'd0);
        chk("a5_gap_done", 32'(done_a), 32'd0);
        tick;
        chk("a5_after_ready", 32'(ready_a), 32'd1);
        chk("a5_after_busy", 32'(busy_a), 32'd0);

        // Inputs wiggled while busy are ignored
        push_word(1'b0, 8'h3C);
        data_a = 8'h3C; lv_a = 1'b1;
        tick;
        data_a = 8'hFF;
        repeat (3) tick;
        data_a = 8'h00;
        tick;
        lv_a = 1'b0;
        wait_idle(1'b0, "ignore_idle");
        repeat (3) tick;

        // Parity-oriented words (parity bit expected only when enabled)
        push_word(1'b0, 8'h07);
        data_a = 8'h07; lv_a = 1'b1;
        tick;
        lv_a = 1'b0;
        wait_idle(1'b0, "w07_idle");
        push_word(1'b0, 8'h03);
        data_a = 8'h03; lv_a = 1'b1;
        tick;
        lv_a = 1'b0;
        wait_idle(1'b0, "w03_idle");

        // Mid-word reset on the 4th bit of 0xC3
        for (int i = 7; i >= 4; i--) begin
            e.b = c3[i];
            e.d = 1'b0;
            qa.push_back(e);
        end
        data_a = 8'hC3; lv_a = 1'b1;
        tick;
        lv_a = 1'b0;
        repeat (3) tick;
        rst = 1'b1;
        tick;
        chk("abort_valid", 32'(sv_a), 32'd0);
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_done", 32'(done_a), 32'd0);
        chk("abort_sdo", 32'(sdo_a), 32'd0);
        chk("abort_ready", 32'(ready_a), 32'd0);
        rst = 1'b0;
        tick;
        chk("abort_ready_back", 32'(ready_a), 32'd1);
        chk("abort_drained", 32'(qa.size()), 32'd0);
        push_word(1'b0, 8'h81);
        data_a = 8'h81; lv_a = 1'b1;
        tick;
        lv_a = 1'b0;
        wait_idle(1'b0, "w81_idle");

        // Back-to-back on the GAP=0 instance with load_valid held high
        push_word(1'b1, 8'hFF);
        push_word(1'b1, 8'h00);
        chk("b2b_ready_first", 32'(ready_b), 32'd1);
        data_b = 8'hFF; lv_b = 1'b1;
        tick;
        data_b = 8'h00;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 30) begin
            acc = ready_b;
            if (acc) chk("b2b_idle_valid", 32'(sv_b), 32'd0);
            tick;
            n++;
        end
        lv_b = 1'b0;
        chk("b2b_period", 32'(n), 32'(NB + 1));
        wait_idle(1'b1, "b2b_idle");
        repeat (2) tick;
        chk("b2b_done_count", 32'(done_cyc_b.size()), 32'd2);
        if (done_cyc_b.size() == 2)
            chk("b2b_done_spacing", 32'(done_cyc_b[1] - done_cyc_b[0]), 32'(NB + 1));

        repeat (3) tick;
        chk("qa_empty", 32'(qa.size()), 32'd0);
        chk("qb_empty", 32'(qb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
